// File: rtl/pipeline_hazard_ctrl.sv
// Hazard sequencer for the 5-stage pipe: load-use bubbles, redirect flushes and memory-wait freezes.
// Optional perf counters are built only when HAZARD_PERF_CNT_EN is defined.
module pipeline_hazard_ctrl #(
  parameter int REG_ADDR_W   = 5,
  parameter int FLUSH_CYCLES = 1,
  parameter int MEM_TIMEOUT  = 255
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [REG_ADDR_W-1:0] i_id_rs1,
  input  logic [REG_ADDR_W-1:0] i_id_rs2,
  input  logic                  i_id_use_rs1,
  input  logic                  i_id_use_rs2,
  input  logic [REG_ADDR_W-1:0] i_ex_rd,
  input  logic                  i_ex_mem_read,
  input  logic                  i_ex_redirect,
  input  logic                  i_mem_req,
  input  logic                  i_mem_ready,
  output logic                  o_pc_en,
  output logic                  o_if_id_en,
  output logic                  o_if_id_clear,
  output logic                  o_id_ex_en,
  output logic                  o_id_ex_clear,
  output logic                  o_ex_mem_en,
  output logic [1:0]            o_state,
  output logic                  o_mem_timeout,
  output logic [31:0]           o_stall_cycles,
  output logic [31:0]           o_flush_count
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_LU_STALL = 2'd1,
    ST_FLUSH    = 2'd2,
    ST_MEM_WAIT = 2'd3
  } state_t;

  localparam int              FC_W        = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [FC_W-1:0] FLUSH_LOAD  = FC_W'(FLUSH_CYCLES - 1);
  localparam logic [7:0]      TIMEOUT_VAL = 8'(MEM_TIMEOUT);

  state_t          state_r, state_nxt_s;
  logic [FC_W-1:0] flush_cnt_r, flush_cnt_nxt_s;
  logic [7:0]      wait_cnt_r, wait_cnt_nxt_s;
  logic            memwait_s, load_use_s, run_eval_s, timeout_s, redirect_take_s;
  logic            pc_en_s, if_id_en_s, if_id_clear_s, id_ex_en_s, id_ex_clear_s, ex_mem_en_s;

  assign memwait_s  = i_mem_req & ~i_mem_ready;
  assign load_use_s = i_ex_mem_read & (i_ex_rd != '0) &
                      ((i_id_use_rs1 & (i_id_rs1 == i_ex_rd)) |
                       (i_id_use_rs2 & (i_id_rs2 == i_ex_rd)));

  // Next-state and per-cycle control decode
  always_comb begin
    state_nxt_s     = state_r;
    flush_cnt_nxt_s = flush_cnt_r;
    wait_cnt_nxt_s  = wait_cnt_r;
    run_eval_s      = 1'b0;
    timeout_s       = 1'b0;
    redirect_take_s = 1'b0;
    pc_en_s         = 1'b1;
    if_id_en_s      = 1'b1;
    id_ex_en_s      = 1'b1;
    ex_mem_en_s     = 1'b1;
    if_id_clear_s   = 1'b0;
    id_ex_clear_s   = 1'b0;

    case (state_r)
      ST_MEM_WAIT: begin
        if (memwait_s && (wait_cnt_r != TIMEOUT_VAL)) begin
          {pc_en_s, if_id_en_s, id_ex_en_s, ex_mem_en_s} = 4'b0000;
          wait_cnt_nxt_s = wait_cnt_r + 8'd1;
        end else begin
          timeout_s      = memwait_s;
          wait_cnt_nxt_s = 8'd0;
          // A flush interrupted by the freeze resumes; otherwise decode as RUN.
          if (flush_cnt_r != '0) begin
            state_nxt_s = ST_FLUSH;
          end else begin
            state_nxt_s = ST_RUN;
            run_eval_s  = 1'b1;
          end
        end
      end
      ST_FLUSH: begin
        if (memwait_s) begin
          {pc_en_s, if_id_en_s, id_ex_en_s, ex_mem_en_s} = 4'b0000;
          state_nxt_s = ST_MEM_WAIT;
        end else begin
          if_id_clear_s   = 1'b1;
          id_ex_clear_s   = 1'b1;
          flush_cnt_nxt_s = flush_cnt_r - FC_W'(1);
          state_nxt_s     = (flush_cnt_r == FC_W'(1)) ? ST_RUN : ST_FLUSH;
        end
      end
      ST_RUN, ST_LU_STALL: begin
        if (memwait_s) begin
          {pc_en_s, if_id_en_s, id_ex_en_s, ex_mem_en_s} = 4'b0000;
          state_nxt_s = ST_MEM_WAIT;
        end else begin
          state_nxt_s = ST_RUN;
          run_eval_s  = 1'b1;
        end
      end
      default: begin
        state_nxt_s = ST_RUN;
      end
    endcase

    if (run_eval_s) begin
      if (i_ex_redirect) begin
        redirect_take_s = 1'b1;
        if_id_clear_s   = 1'b1;
        id_ex_clear_s   = 1'b1;
        flush_cnt_nxt_s = FLUSH_LOAD;
        state_nxt_s     = (FLUSH_LOAD != '0) ? ST_FLUSH : ST_RUN;
      end else if (load_use_s) begin
        pc_en_s       = 1'b0;
        if_id_en_s    = 1'b0;
        id_ex_clear_s = 1'b1;
        state_nxt_s   = ST_LU_STALL;
      end else begin
        state_nxt_s = ST_RUN;
      end
    end else begin
      redirect_take_s = 1'b0;
    end
  end

  // Reset forces all enables low and both clears high
  always_comb begin
    if (!i_rst_n) begin
      {o_pc_en, o_if_id_en, o_id_ex_en, o_ex_mem_en} = 4'b0000;
      o_if_id_clear = 1'b1;
      o_id_ex_clear = 1'b1;
      o_mem_timeout = 1'b0;
    end else begin
      o_pc_en       = pc_en_s;
      o_if_id_en    = if_id_en_s;
      o_id_ex_en    = id_ex_en_s;
      o_ex_mem_en   = ex_mem_en_s;
      o_if_id_clear = if_id_clear_s;
      o_id_ex_clear = id_ex_clear_s;
      o_mem_timeout = timeout_s;
    end
  end

  assign o_state = state_r;

  // FSM state, flush remainder and wait counter
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r     <= ST_RUN;
      flush_cnt_r <= '0;
      wait_cnt_r  <= 8'd0;
    end else begin
      state_r     <= state_nxt_s;
      flush_cnt_r <= flush_cnt_nxt_s;
      wait_cnt_r  <= wait_cnt_nxt_s;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles_r, flush_count_r;

  // Saturating performance counters
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      stall_cycles_r <= 32'h0;
      flush_count_r  <= 32'h0;
    end else begin
      if (!pc_en_s && (stall_cycles_r != 32'hFFFF_FFFF)) begin
        stall_cycles_r <= stall_cycles_r + 32'd1;
      end
      if (redirect_take_s && (flush_count_r != 32'hFFFF_FFFF)) begin
        flush_count_r <= flush_count_r + 32'd1;
      end
    end
  end

  assign o_stall_cycles = stall_cycles_r;
  assign o_flush_count  = flush_count_r;
`else
  assign o_stall_cycles = 32'h0;
  assign o_flush_count  = 32'h0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl (FLUSH_CYCLES=2, MEM_TIMEOUT=4).
module tb_pipeline_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  id_rs1, id_rs2, ex_rd;
  logic        id_use_rs1, id_use_rs2, ex_mem_read, ex_redirect, mem_req, mem_ready;
  logic        pc_en, if_id_en, if_id_clear, id_ex_en, id_ex_clear, ex_mem_en, mem_timeout;
  logic [1:0]  state;
  logic [31:0] stall_cycles, flush_count;

  pipeline_hazard_ctrl #(.REG_ADDR_W(5), .FLUSH_CYCLES(2), .MEM_TIMEOUT(4)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_id_rs1(id_rs1), .i_id_rs2(id_rs2), .i_id_use_rs1(id_use_rs1), .i_id_use_rs2(id_use_rs2),
    .i_ex_rd(ex_rd), .i_ex_mem_read(ex_mem_read), .i_ex_redirect(ex_redirect),
    .i_mem_req(mem_req), .i_mem_ready(mem_ready),
    .o_pc_en(pc_en), .o_if_id_en(if_id_en), .o_if_id_clear(if_id_clear),
    .o_id_ex_en(id_ex_en), .o_id_ex_clear(id_ex_clear), .o_ex_mem_en(ex_mem_en),
    .o_state(state), .o_mem_timeout(mem_timeout),
    .o_stall_cycles(stall_cycles), .o_flush_count(flush_count)
  );

  always #5 clk = ~clk;

  // {pc_en, if_id_en, if_id_clear, id_ex_en, id_ex_clear, ex_mem_en, state[1:0], mem_timeout}
  localparam logic [8:0] E_RST     = 9'b001010_00_0;
  localparam logic [8:0] E_RUN     = 9'b110101_00_0;
  localparam logic [8:0] E_LU      = 9'b000111_00_0;
  localparam logic [8:0] E_LUS     = 9'b110101_01_0;
  localparam logic [8:0] E_RDR     = 9'b111111_00_0;
  localparam logic [8:0] E_RDR_LUS = 9'b111111_01_0;
  localparam logic [8:0] E_FL      = 9'b111111_10_0;
  localparam logic [8:0] E_FRZ_RUN = 9'b000000_00_0;
  localparam logic [8:0] E_FRZ_FL  = 9'b000000_10_0;
  localparam logic [8:0] E_FRZ_MW  = 9'b000000_11_0;
  localparam logic [8:0] E_MW_EXIT = 9'b110101_11_0;
  localparam logic [8:0] E_MW_TO   = 9'b110101_11_1;
  localparam logic [8:0] E_MW_RDR  = 9'b111111_11_0;

  typedef struct {
    string       nm;
    logic [8:0]  exp;
    logic [31:0] stall;
    logic [31:0] flush;
  } rec_t;

  rec_t        sb[$];
  int          total = 0;
  int          bad = 0;
  logic [31:0] m_stall = 32'd0;
  logic [31:0] m_flush = 32'd0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0;
    id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; ex_mem_read = 1'b0;
    ex_redirect = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
  endtask

  task automatic lu_in(input logic [4:0] r);
    ex_mem_read = 1'b1; ex_rd = r; id_rs1 = r; id_use_rs1 = 1'b1;
  endtask

  // Push the expected response for the current cycle and advance the perf model
  task automatic expect_out(input string nm, input logic [8:0] e, input bit redir);
    rec_t r;
    if (!rst_n) begin
      m_stall = 32'd0;
      m_flush = 32'd0;
    end
    r.nm = nm; r.exp = e; r.stall = m_stall; r.flush = m_flush;
    sb.push_back(r);
    if (rst_n) begin
      if (!e[8]) m_stall = m_stall + 32'd1;
      if (redir) m_flush = m_flush + 32'd1;
    end
  endtask

  // Monitor: pop one expectation per cycle and compare on the falling edge
  always @(negedge clk) begin
    if (sb.size() != 0) begin
      rec_t        r;
      logic [8:0]  act;
      logic [31:0] es, ef;
      r   = sb.pop_front();
      act = {pc_en, if_id_en, if_id_clear, id_ex_en, id_ex_clear, ex_mem_en, state, mem_timeout};
      total = total + 1;
      if (act !== r.exp) begin
        bad = bad + 1;
        $display("FAIL %s ctrl: got %b expected %b", r.nm, act, r.exp);
      end
`ifdef HAZARD_PERF_CNT_EN
      es = r.stall; ef = r.flush;
`else
      es = 32'd0; ef = 32'd0;
`endif
      total = total + 1;
      if ((stall_cycles !== es) || (flush_count !== ef)) begin
        bad = bad + 1;
        $display("FAIL %s perf: got stall=%0d flush=%0d expected stall=%0d flush=%0d",
                 r.nm, stall_cycles, flush_count, es, ef);
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    clr_in();
    tick(); expect_out("rst0", E_RST, 0);
    tick(); expect_out("rst1", E_RST, 0);
    tick(); rst_n = 1'b1; expect_out("release", E_RUN, 0);
    tick(); expect_out("idle", E_RUN, 0);

    // load-use via rs2, then via rs1
    tick(); ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs2 = 5'd5; id_use_rs2 = 1'b1;
    expect_out("lu_rs2", E_LU, 0);
    tick(); clr_in(); expect_out("lu_rs2_stall", E_LUS, 0);
    tick(); expect_out("lu_rs2_back", E_RUN, 0);
    tick(); lu_in(5'd7); id_rs2 = 5'd3; id_use_rs2 = 1'b1; expect_out("lu_rs1", E_LU, 0);
    tick(); clr_in(); expect_out("lu_rs1_stall", E_LUS, 0);

    // non-hazards: rd=x0, unused operand, not a load
    tick(); ex_mem_read = 1'b1; id_use_rs1 = 1'b1; id_use_rs2 = 1'b1; expect_out("rd_x0", E_RUN, 0);
    tick(); clr_in(); ex_mem_read = 1'b1; ex_rd = 5'd9; id_rs1 = 5'd9; id_rs2 = 5'd4; id_use_rs2 = 1'b1;
    expect_out("no_use", E_RUN, 0);
    tick(); clr_in(); ex_rd = 5'd4; id_rs2 = 5'd4; id_use_rs2 = 1'b1; expect_out("not_load", E_RUN, 0);
    tick(); clr_in(); expect_out("idle2", E_RUN, 0);

    // redirect, held high with a load-use during FLUSH (both masked)
    tick(); ex_redirect = 1'b1; expect_out("redir", E_RDR, 1);
    tick(); lu_in(5'd5); expect_out("redir_flush", E_FL, 0);
    tick(); clr_in(); expect_out("redir_done", E_RUN, 0);

    // redirect and load-use together: redirect wins, no bubble
    tick(); ex_redirect = 1'b1; lu_in(5'd6); expect_out("redir_lu", E_RDR, 1);
    tick(); clr_in(); expect_out("redir_lu_flush", E_FL, 0);
    tick(); expect_out("redir_lu_done", E_RUN, 0);

    // redirect taken from LU_STALL
    tick(); lu_in(5'd8); expect_out("lu_then_redir", E_LU, 0);
    tick(); clr_in(); ex_redirect = 1'b1; expect_out("redir_in_lus", E_RDR_LUS, 1);
    tick(); clr_in(); expect_out("redir_lus_flush", E_FL, 0);
    tick(); expect_out("redir_lus_done", E_RUN, 0);

    // memory wait: three frozen cycles then ready
    tick(); mem_req = 1'b1; expect_out("mw_enter", E_FRZ_RUN, 0);
    tick(); expect_out("mw_wait1", E_FRZ_MW, 0);
    tick(); expect_out("mw_wait2", E_FRZ_MW, 0);
    tick(); mem_ready = 1'b1; expect_out("mw_ready", E_MW_EXIT, 0);
    tick(); clr_in(); expect_out("mw_done", E_RUN, 0);

    // timeout: ready never arrives, pulse on the fifth MEM_WAIT cycle
    tick(); mem_req = 1'b1; expect_out("to_enter", E_FRZ_RUN, 0);
    for (int i = 0; i < 4; i++) begin
      tick(); expect_out("to_wait", E_FRZ_MW, 0);
    end
    tick(); expect_out("to_pulse", E_MW_TO, 0);
    tick(); clr_in(); expect_out("to_done", E_RUN, 0);

    // priority: memwait + redirect + load-use freezes, redirect taken on ready
    tick(); mem_req = 1'b1; ex_redirect = 1'b1; lu_in(5'd5); expect_out("prio_freeze", E_FRZ_RUN, 0);
    tick(); expect_out("prio_wait", E_FRZ_MW, 0);
    tick(); mem_ready = 1'b1; expect_out("prio_ready", E_MW_RDR, 1);
    tick(); clr_in(); expect_out("prio_flush", E_FL, 0);
    tick(); expect_out("prio_done", E_RUN, 0);

    // memwait during FLUSH keeps the remaining flush count
    tick(); ex_redirect = 1'b1; expect_out("fl_redir", E_RDR, 1);
    tick(); ex_redirect = 1'b0; mem_req = 1'b1; expect_out("fl_freeze", E_FRZ_FL, 0);
    tick(); mem_ready = 1'b1; expect_out("fl_ready", E_MW_EXIT, 0);
    tick(); clr_in(); expect_out("fl_resume", E_FL, 0);
    tick(); expect_out("fl_done", E_RUN, 0);

    // async reset in the middle of MEM_WAIT
    tick(); mem_req = 1'b1; expect_out("rmw_enter", E_FRZ_RUN, 0);
    tick(); expect_out("rmw_wait", E_FRZ_MW, 0);
    tick(); rst_n = 1'b0; expect_out("rmw_reset", E_RST, 0);
    tick(); expect_out("rmw_hold", E_RST, 0);
    tick(); rst_n = 1'b1; clr_in(); expect_out("rmw_release", E_RUN, 0);

    // fresh counters: a three-cycle freeze gives stall_cycles=3
    tick(); mem_req = 1'b1; expect_out("cnt_enter", E_FRZ_RUN, 0);
    tick(); expect_out("cnt_wait1", E_FRZ_MW, 0);
    tick(); expect_out("cnt_wait2", E_FRZ_MW, 0);
    tick(); mem_ready = 1'b1; expect_out("cnt_ready", E_MW_EXIT, 0);
    tick(); clr_in(); expect_out("cnt_done", E_RUN, 0);

    tick();
    tick();
    total = total + 1;
    if (sb.size() != 0) begin
      bad = bad + 1;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
